conv_window_sequencer: RTL and testbench
========================================

// Module: conv_window_sequencer
// PURPOSE
//   Sequences one multiplier + adder_tree convolution datapath (KERN_DIM x KERN_DIM window, one output).
//   Serially loads the kernel weights and bias, then repeatedly loads a pixel window.
//   Holds the packed operand buses stable while the datapath settles, then captures the adder_tree result.
//   Presents that result on a valid/ready output. Sits between the line-buffer pixel stream and the MAC datapath.
// PARAMETERS
//   DATA_WIDTH   16  width of each weight, pixel, bias and result (signed, Q8.8 fixed point)
//   KERN_DIM     5   kernel edge length; KERNEL_SIZE = KERN_DIM*KERN_DIM (25) operand slots
//   MAC_LATENCY  0   pipeline registers inside multiplier+adder_tree; WAIT lasts MAC_LATENCY+1 cycles
// PORTS
//   clk              in   1                       clock, rising edge
//   rstn             in   1                       asynchronous active-low reset
//   cfg_start        in   1                       begin a weight load; bias_in is sampled on the same cycle
//   bias_in          in   DATA_WIDTH              bias value, latched on an accepted cfg_start
//   w_valid          in   1                       weight word valid
//   w_data           in   DATA_WIDTH              weight word, row-major, slot 0 first
//   w_ready          out  1                       weight word accepted when w_valid&&w_ready
//   pix_valid        in   1                       pixel valid
//   pix_data         in   DATA_WIDTH              pixel, row-major, slot 0 first
//   pix_ready        out  1                       pixel accepted when pix_valid&&pix_ready
//   mult_weights     out  KERNEL_SIZE*DATA_WIDTH  slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   mult_pixel_data  out  KERNEL_SIZE*DATA_WIDTH  slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   adder_bias       out  DATA_WIDTH              bias driven to the adder_tree
//   mac_result       in   DATA_WIDTH              adder_tree result
//   out_valid        out  1                       out_data valid; held until out_ready
//   out_data         out  DATA_WIDTH              captured convolution result
//   out_ready        in   1                       downstream accepts when out_valid&&out_ready
//   weights_loaded   out  1                       a full kernel set is resident
//   busy             out  1                       state != IDLE
// BEHAVIOUR
//   Reset (async, rstn=0): every output and register is 0, including both buses, counters and weights_loaded. State is IDLE.
//   FSM states: IDLE, LOAD_W, LOAD_P, WAIT, OUT.
//   IDLE:
//     - cfg_start=1 -> LOAD_W. Latch bias_in into adder_bias. Clear w_cnt and weights_loaded.
//   LOAD_W:
//     - w_ready=1. Each accepted word is written to slot w_cnt, then w_cnt++.
//     - Accepting the word at w_cnt=KERNEL_SIZE-1 -> LOAD_P. weights_loaded<=1. p_cnt<=0.
//     - cfg_start is ignored in LOAD_W.
//   LOAD_P:
//     - pix_ready = !(cfg_start && p_cnt==0).
//     - Each accepted pixel is written to slot p_cnt, then p_cnt++.
//     - Accepting the pixel at p_cnt=KERNEL_SIZE-1 -> WAIT. wait_cnt<=0.
//     - cfg_start with p_cnt==0 -> LOAD_W (reload; the same cfg_start/bias rules as in IDLE apply).
//     - cfg_start with p_cnt!=0 is ignored; a partial window is never abandoned.
//   WAIT:
//     - pix_ready=0 and w_ready=0. Increment wait_cnt each cycle.
//     - At the cycle where wait_cnt==MAC_LATENCY: out_data<=mac_result, out_valid<=1, -> OUT.
//   OUT:
//     - out_valid=1. out_data is stable and pix_ready=0.
//     - out_ready=1 -> out_valid<=0, p_cnt<=0, -> LOAD_P. Weights and bias are retained.
//     - No bubble is required: out_valid may be high with out_ready high on its first cycle.
//   Bus stability:
//     - mult_weights and adder_bias change only in LOAD_W, or on cfg_start.
//     - A mult_pixel_data slot changes only when a pixel is written to that slot.
//     - Both buses are therefore constant through WAIT and OUT.
//   Latency: the last pixel accepted at cycle N gives out_valid=1 at cycle N+MAC_LATENCY+2.
//   Arithmetic: no arithmetic is done here. out_data is mac_result bit-exact, and overflow is the adder_tree's concern.
//   Counters: w_cnt and p_cnt are $clog2(KERNEL_SIZE) wide and never exceed KERNEL_SIZE-1.
//   Reset during any state aborts the operation immediately. weights_loaded returns to 0.
// TESTING
//   1. Reset then idle:
//      - Required: all outputs 0; pix_ready=0 and w_ready=0 while in IDLE.
//   2. Weights, pixels and bias:
//      - Stimulus: cfg_start with bias_in=16'h0100, then 25 weights of 16'h0100 (1.0), then 25 pixels of 16'h0200.
//      - Required: out_valid after MAC_LATENCY+2 cycles; out_data equals the mac_result model (50.0+1.0=16'h3300).
//   3. Backpressure:
//      - Stimulus: hold out_ready=0 for 10 cycles.
//      - Required: out_valid and out_data stable and pix_ready=0 throughout; one handshake when out_ready=1; back to LOAD_P.
//   4. Gapped input:
//      - Stimulus: toggle w_valid and pix_valid randomly 50%.
//      - Required: slot i holds the i-th accepted word; exactly one result per 25 pixels.
//   5. Ignored cfg_start:
//      - Stimulus: cfg_start at p_cnt=12.
//      - Required: ignored. cfg_start at p_cnt=0 with pix_valid=1: pix_ready=0, state goes to LOAD_W, weights_loaded=0.
//   6. Mid-load reset:
//      - Stimulus: rstn=0 mid-LOAD_W (w_cnt=7).
//      - Required: immediate zeroing; the next cfg_start restarts at slot 0.

Source files
------------

// File: rtl/conv_window_sequencer_if.sv
// Handshake and operand bus bundle between the pixel/weight sources, the sequencer and the MAC datapath.
interface conv_window_sequencer_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 25
);
  logic                              cfg_start;
  logic [DATA_WIDTH-1:0]             bias_in;
  logic                              w_valid;
  logic [DATA_WIDTH-1:0]             w_data;
  logic                              w_ready;
  logic                              pix_valid;
  logic [DATA_WIDTH-1:0]             pix_data;
  logic                              pix_ready;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] mult_weights;
  logic [KERNEL_SIZE*DATA_WIDTH-1:0] mult_pixel_data;
  logic [DATA_WIDTH-1:0]             adder_bias;
  logic [DATA_WIDTH-1:0]             mac_result;
  logic                              out_valid;
  logic [DATA_WIDTH-1:0]             out_data;
  logic                              out_ready;
  logic                              weights_loaded;
  logic                              busy;

  modport slave (
    input  cfg_start, bias_in, w_valid, w_data, pix_valid, pix_data, mac_result, out_ready,
    output w_ready, pix_ready, mult_weights, mult_pixel_data, adder_bias, out_valid, out_data,
           weights_loaded, busy
  );

  modport master (
    output cfg_start, bias_in, w_valid, w_data, pix_valid, pix_data, mac_result, out_ready,
    input  w_ready, pix_ready, mult_weights, mult_pixel_data, adder_bias, out_valid, out_data,
           weights_loaded, busy
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Loads kernel weights and bias, then streams pixel windows into a MAC datapath,
// holding operand buses steady while it settles and returning each result on valid/ready.
module conv_window_sequencer #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERN_DIM    = 5,
  parameter int unsigned MAC_LATENCY = 0
) (
  input logic                    clk,
  input logic                    rstn,
  conv_window_sequencer_if.slave bus
);
  localparam int unsigned KernelSize = KERN_DIM * KERN_DIM;
  localparam int unsigned CntW       = $clog2(KernelSize);
  localparam int unsigned WaitW      = (MAC_LATENCY > 0) ? $clog2(MAC_LATENCY + 1) : 1;
  localparam logic [CntW-1:0]  LastSlot = CntW'(KernelSize - 1);
  localparam logic [WaitW-1:0] LastWait = WaitW'(MAC_LATENCY);

  typedef enum logic [2:0] {StIdle, StLoadW, StLoadP, StWait, StOut} state_e;

  state_e                state;
  logic [CntW-1:0]       w_cnt;
  logic [CntW-1:0]       p_cnt;
  logic [WaitW-1:0]      wait_cnt;
  logic [DATA_WIDTH-1:0] weights [KernelSize];
  logic [DATA_WIDTH-1:0] pixels  [KernelSize];
  logic [DATA_WIDTH-1:0] bias;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  weights_loaded;
  logic                  restart;
  logic                  w_fire;
  logic                  p_fire;
  logic                  pix_ready;

  // A reload is only honoured between windows, never part-way through one.
  assign restart   = bus.cfg_start &&
                     ((state == StIdle) || ((state == StLoadP) && (p_cnt == '0)));
  assign pix_ready = (state == StLoadP) && !restart;
  assign w_fire    = (state == StLoadW) && bus.w_valid;
  assign p_fire    = pix_ready && bus.pix_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= StIdle;
      w_cnt          <= '0;
      p_cnt          <= '0;
      wait_cnt       <= '0;
      bias           <= '0;
      out_data       <= '0;
      out_valid      <= 1'b0;
      weights_loaded <= 1'b0;
      for (int i = 0; i < KernelSize; i++) begin
        weights[i] <= '0;
        pixels[i]  <= '0;
      end
    end else if (restart) begin
      state          <= StLoadW;
      bias           <= bus.bias_in;
      w_cnt          <= '0;
      weights_loaded <= 1'b0;
    end else begin
      unique case (state)
        StLoadW: begin
          if (w_fire) begin
            weights[w_cnt] <= bus.w_data;
            if (w_cnt == LastSlot) begin
              state          <= StLoadP;
              weights_loaded <= 1'b1;
              w_cnt          <= '0;
              p_cnt          <= '0;
            end else begin
              w_cnt <= w_cnt + 1'b1;
            end
          end
        end
        StLoadP: begin
          if (p_fire) begin
            pixels[p_cnt] <= bus.pix_data;
            if (p_cnt == LastSlot) begin
              state    <= StWait;
              wait_cnt <= '0;
            end else begin
              p_cnt <= p_cnt + 1'b1;
            end
          end
        end
        StWait: begin
          if (wait_cnt == LastWait) begin
            out_data  <= bus.mac_result;
            out_valid <= 1'b1;
            state     <= StOut;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        StOut: begin
          if (bus.out_ready) begin
            out_valid <= 1'b0;
            p_cnt     <= '0;
            state     <= StLoadP;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_comb begin
    bus.mult_weights    = '0;
    bus.mult_pixel_data = '0;
    for (int i = 0; i < KernelSize; i++) begin
      bus.mult_weights[i*DATA_WIDTH +: DATA_WIDTH]    = weights[i];
      bus.mult_pixel_data[i*DATA_WIDTH +: DATA_WIDTH] = pixels[i];
    end
  end

  assign bus.w_ready        = (state == StLoadW);
  assign bus.pix_ready      = pix_ready;
  assign bus.adder_bias     = bias;
  assign bus.out_valid      = out_valid;
  assign bus.out_data       = out_data;
  assign bus.weights_loaded = weights_loaded;
  assign bus.busy           = (state != StIdle);
endmodule

// File: tb/tb_conv_window_sequencer.sv
// Randomised scoreboard bench: a behavioural convolution model predicts each result and its
// arrival cycle; a monitor pops and compares whenever the sequencer presents an output.
module tb_conv_window_sequencer;
  localparam int unsigned DW  = 16;
  localparam int unsigned KS  = 25;
  localparam int unsigned LAT = 0;

  logic clk;
  logic rstn;
  int   total;
  int   bad;
  int   cyc;
  int   rdy_mode;

  logic [DW-1:0] ref_w [KS];
  logic [DW-1:0] ref_p [KS];
  logic [DW-1:0] ref_bias;
  logic [DW-1:0] exp_q [$];
  int            lat_q [$];

  logic          prev_valid;
  logic          prev_fire;
  logic [DW-1:0] prev_data;

  conv_window_sequencer_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS)) bus ();

  conv_window_sequencer #(.DATA_WIDTH(DW), .KERN_DIM(5), .MAC_LATENCY(LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Zero-latency multiplier + adder_tree: Q8.8 products summed, rescaled, bias added.
  always_comb begin
    longint acc;
    acc = 0;
    for (int i = 0; i < KS; i++) begin
      acc = acc + longint'($signed(bus.mult_weights[i*DW +: DW])) *
                  longint'($signed(bus.mult_pixel_data[i*DW +: DW]));
    end
    bus.mac_result = DW'(acc >>> 8) + bus.adder_bias;
  end

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'b0;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [DW-1:0] conv_model();
    longint acc;
    acc = 0;
    for (int i = 0; i < KS; i++) acc += longint'($signed(ref_w[i])) * longint'($signed(ref_p[i]));
    return DW'(acc >>> 8) + ref_bias;
  endfunction

  // Monitor: latency, pixel slots on arrival, hold stability, data on handshake.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_valid = 1'b0;
      prev_fire  = 1'b0;
    end else begin
      if (bus.out_valid) begin
        chk("pix_ready low in OUT", bus.pix_ready, 0);
        if (!prev_valid) begin
          if (lat_q.size() == 0) begin
            chk("unexpected out_valid", 1, 0);
          end else begin
            int n;
            int lat;
            lat = lat_q.pop_front();
            chk("result latency", cyc, lat + LAT + 2);
            n = 0;
            for (int i = 0; i < KS; i++)
              if (bus.mult_pixel_data[i*DW +: DW] !== ref_p[i]) n++;
            chk("pixel slots", n, 0);
          end
        end else if (!prev_fire) begin
          chk("out_data held", bus.out_data, prev_data);
        end
        if (bus.out_ready) begin
          if (exp_q.size() == 0) chk("result with no expectation", 1, 0);
          else chk("out_data", bus.out_data, exp_q.pop_front());
        end
      end
      prev_valid = bus.out_valid;
      prev_fire  = bus.out_valid && bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, " out_valid"}, bus.out_valid, 0);
    chk({tag, " out_data"}, bus.out_data, 0);
    chk({tag, " w_ready"}, bus.w_ready, 0);
    chk({tag, " pix_ready"}, bus.pix_ready, 0);
    chk({tag, " weights_loaded"}, bus.weights_loaded, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " adder_bias"}, bus.adder_bias, 0);
    chk({tag, " weight bus"}, (bus.mult_weights != '0), 0);
    chk({tag, " pixel bus"}, (bus.mult_pixel_data != '0), 0);
  endtask

  task automatic check_weights();
    int n;
    n = 0;
    for (int i = 0; i < KS; i++) if (bus.mult_weights[i*DW +: DW] !== ref_w[i]) n++;
    chk("weight slots", n, 0);
    chk("adder_bias", bus.adder_bias, ref_bias);
    chk("weights_loaded set", bus.weights_loaded, 1);
  endtask

  // Entered at posedge+1 with the DUT idle or between windows.
  task automatic load_weights(input logic [DW-1:0] bias, input bit gapped, input bit rnd,
                              input logic [DW-1:0] wval, input bit with_pix);
    int  budget;
    bit  fire;
    bus.cfg_start = 1'b1;
    bus.bias_in   = bias;
    bus.pix_valid = with_pix;
    bus.w_valid   = 1'b0;
    @(negedge clk);
    chk("w_ready low on cfg_start", bus.w_ready, 0);
    chk("pix_ready blocked by cfg_start", bus.pix_ready, 0);
    @(posedge clk);
    #1;
    bus.cfg_start = 1'b0;
    bus.pix_valid = 1'b0;
    ref_bias      = bias;
    @(negedge clk);
    chk("weights_loaded cleared", bus.weights_loaded, 0);
    chk("w_ready in LOAD_W", bus.w_ready, 1);
    chk("busy in LOAD_W", bus.busy, 1);
    @(posedge clk);
    #1;
    budget = 0;
    for (int i = 0; i < KS;) begin
      bus.w_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.w_data  = rnd ? DW'($urandom) : wval;
      @(negedge clk);
      fire = bus.w_valid && bus.w_ready;
      @(posedge clk);
      #1;
      if (fire) begin
        ref_w[i] = bus.w_data;
        i++;
      end
      if (++budget > 2000) begin
        chk("weight load timeout", 0, 1);
        break;
      end
    end
    bus.w_valid = 1'b0;
  endtask

  task automatic pixel_window(input bit gapped, input bit rnd, input logic [DW-1:0] pval,
                              input int inject);
    int budget;
    bit fire;
    budget = 0;
    for (int i = 0; i < KS;) begin
      bus.pix_valid = (gapped && i != inject) ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_data  = rnd ? DW'($urandom) : pval;
      bus.cfg_start = (i == inject);
      bus.bias_in   = DW'($urandom);
      @(negedge clk);
      fire = bus.pix_valid && bus.pix_ready;
      if (i == inject) chk("mid-window cfg_start ignored", bus.pix_ready, 1);
      if (fire) begin
        ref_p[i] = bus.pix_data;
        if (i == KS - 1) begin
          exp_q.push_back(conv_model());
          lat_q.push_back(cyc);
        end
      end
      @(posedge clk);
      #1;
      bus.cfg_start = 1'b0;
      if (fire) i++;
      if (++budget > 2000) begin
        chk("pixel window timeout", 0, 1);
        break;
      end
    end
    bus.pix_valid = 1'b0;
    if (inject >= 0) chk("weights_loaded kept", bus.weights_loaded, 1);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0) begin
      @(posedge clk);
      #1;
      if (++budget > 500) begin
        chk("result drain timeout", exp_q.size(), 0);
        break;
      end
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    cyc = 0;
    rdy_mode = 0;
    rstn = 1'b0;
    bus.cfg_start = 1'b0;
    bus.bias_in = '0;
    bus.w_valid = 1'b0;
    bus.w_data = '0;
    bus.pix_valid = 1'b0;
    bus.pix_data = '0;
    bus.out_ready = 1'b1;

    // Reset then idle
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle w_ready", bus.w_ready, 0);
      chk("idle pix_ready", bus.pix_ready, 0);
    end
    @(posedge clk);
    #1;

    // 1.0 weights, 2.0 pixels, 1.0 bias -> 16'h3300
    load_weights(16'h0100, 1'b0, 1'b0, 16'h0100, 1'b0);
    @(negedge clk);
    check_weights();
    @(posedge clk);
    #1;
    pixel_window(1'b0, 1'b0, 16'h0200, -1);
    chk("reference 1.0x2.0 window", exp_q[0], 16'h3300);
    drain();

    // Backpressure for 10 cycles
    rdy_mode = 1;
    @(posedge clk);
    #1;
    pixel_window(1'b0, 1'b1, '0, -1);
    begin
      int budget;
      budget = 0;
      while (!bus.out_valid && budget < 50) begin
        @(posedge clk);
        #1;
        budget++;
      end
      chk("out_valid under backpressure", bus.out_valid, 1);
    end
    repeat (10) @(negedge clk);
    rdy_mode = 0;
    drain();
    @(negedge clk);
    chk("back to LOAD_P pix_ready", bus.pix_ready, 1);
    chk("out_valid dropped", bus.out_valid, 0);
    @(posedge clk);
    #1;

    // Gapped random traffic with random downstream ready
    rdy_mode = 2;
    for (int r = 0; r < 3; r++) begin
      load_weights(DW'($urandom), 1'b1, 1'b1, '0, 1'b0);
      @(negedge clk);
      check_weights();
      @(posedge clk);
      #1;
      pixel_window(1'b1, 1'b1, '0, -1);
      pixel_window(1'b1, 1'b1, '0, -1);
      drain();
    end
    rdy_mode = 0;

    // cfg_start mid-window ignored, then honoured at p_cnt==0
    pixel_window(1'b0, 1'b1, '0, 12);
    drain();
    load_weights(DW'($urandom), 1'b0, 1'b1, '0, 1'b1);
    @(negedge clk);
    check_weights();
    @(posedge clk);
    #1;
    pixel_window(1'b1, 1'b1, '0, -1);
    drain();

    // Reset part-way through a weight load
    bus.cfg_start = 1'b1;
    bus.bias_in   = 16'h1234;
    @(posedge clk);
    #1;
    bus.cfg_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.w_valid = 1'b1;
      bus.w_data  = DW'($urandom);
      @(posedge clk);
      #1;
    end
    bus.w_valid = 1'b0;
    #1;
    rstn = 1'b0;
    #1;
    check_zero("mid-load reset");
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    load_weights(DW'($urandom), 1'b0, 1'b1, '0, 1'b0);
    @(negedge clk);
    check_weights();
    @(posedge clk);
    #1;
    pixel_window(1'b0, 1'b1, '0, -1);
    drain();

    repeat (3) @(posedge clk);
    chk("leftover expectations", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
